// File: rtl/clk_div_bank_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_bank_pkg
//   Shared constants for the clock-divider bank. The top level uses them for its
//   default parameters, so every consumer agrees on the oscillator-derived rates.
//
//   CNT_W_DEF   default counter/divisor width
//   DIV_SERIAL  default divisor of the serial-clock channel (channel 0)
//   DIV_DIGIT   default divisor of the digit-clock channel (channel 1)
// -----------------------------------------------------------------------------
package clk_div_bank_pkg;

    localparam int          CNT_W_DEF  = 12;
    localparam logic [11:0] DIV_SERIAL = 12'd255;
    localparam logic [11:0] DIV_DIGIT  = 12'd2047;

endpackage : clk_div_bank_pkg

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
//   One divider channel. The channel toggles clk_out every div_act+1 enabled
//   cycles and raises tick (and, on a 0->1 edge, rise) in that same cycle.
//   A divisor written while the channel runs is parked in div_pend. It takes
//   effect at the next terminal count, so no half-period is ever cut short or
//   stretched.
//
//   Ports
//     clk      in   oscillator clock
//     rst_n    in   synchronous reset, active low
//     en       in   run enable; low forces the channel idle with clk_out low
//     wr       in   divisor write aimed at this channel (already decoded)
//     wr_data  in   new divisor
//     sync     in   phase-align request (tied low when alignment is not built)
//     clk_out  out  divided clock, 50% duty
//     tick     out  one-cycle pulse in the cycle clk_out toggles
//     rise     out  one-cycle pulse in the cycle clk_out goes 0->1
//     pend     out  divisor accepted but not yet applied
// -----------------------------------------------------------------------------
module clk_div_chan #(
    parameter int               CNT_W   = 12,
    parameter logic [CNT_W-1:0] DEF_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             rise,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic             terminal;

    // The >= comparison (rather than ==) keeps the channel from running away
    // through the full counter range if div_act ever drops below cnt.
    assign terminal = (cnt >= div_act);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch reads the pre-edge values of cnt, clk_out and pend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: div_pend is reset along with the live state. This keeps a
            // stale divisor from a previous run from leaking through the
            // sync or disable paths.
            cnt      <= '0;
            div_act  <= DEF_DIV;
            div_pend <= DEF_DIV;
            pend     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            rise     <= 1'b0;
        end else if (sync) begin
            // Alignment restart. Any parked divisor is applied now. A write in
            // this same cycle becomes the new parked value.
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            rise    <= 1'b0;
            if (pend) begin
                div_act <= div_pend;
            end
            pend <= wr;
            if (wr) begin
                div_pend <= wr_data;
            end
        end else if (!en) begin
            // An idle channel has no half-period to protect, so writes land
            // directly. A value still parked from before the disable is
            // applied here too.
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            rise    <= 1'b0;
            pend    <= 1'b0;
            if (wr) begin
                div_act <= wr_data;
            end else if (pend) begin
                div_act <= div_pend;
            end
        end else begin
            if (wr) begin
                div_pend <= wr_data;
                pend     <= 1'b1;
            end
            if (terminal) begin
                clk_out <= ~clk_out;
                tick    <= 1'b1;
                rise    <= ~clk_out;
                cnt     <= '0;
                // A write landing on this terminal waits for the next one.
                // This terminal still uses the old divisor.
                if (pend && !wr) begin
                    div_act <= div_pend;
                    pend    <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
                rise <= 1'b0;
            end
        end
    end

endmodule : clk_div_chan

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//   Bank of NCH programmable clock dividers running from the oscillator clock.
//   Each channel produces a toggled low-rate clock plus aligned tick/rise
//   strobes. The top level decodes divisor writes to one channel and fans the
//   optional phase-align request out to all channels.
//
//   Build option
//     CLKDIV_SYNC_EN  when defined, sync_req restarts every channel
//                     phase-aligned. When undefined, sync_req is accepted but
//                     ignored.
//
//   Ports
//     clk       in   oscillator clock
//     rst_n     in   synchronous reset, active low
//     en        in   per-channel run enable
//     div_wr    in   divisor write strobe, one cycle
//     div_sel   in   target channel; values >= NCH are ignored
//     div_data  in   new divisor
//     sync_req  in   phase-align request
//     clk_out   out  divided clocks
//     tick      out  toggle strobes
//     rise      out  rising-edge strobes
//     pend      out  divisor written but not yet applied
// -----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int                     NCH     = 2,
    parameter int                     CNT_W   = CNT_W_DEF,
    parameter logic [NCH*CNT_W-1:0]   DEF_DIV = {DIV_DIGIT, DIV_SERIAL}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     en,
    input  logic               div_wr,
    input  logic [$clog2(NCH):0] div_sel,
    input  logic [CNT_W-1:0]   div_data,
    input  logic               sync_req,
    output logic [NCH-1:0]     clk_out,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     rise,
    output logic [NCH-1:0]     pend
);

    // The extra select bit lets out-of-range selects be expressed and dropped.
    localparam int SEL_W = $clog2(NCH) + 1;

    logic sync_int;

`ifdef CLKDIV_SYNC_EN
    assign sync_int = sync_req;
`else
    logic unused_sync_req;
    assign unused_sync_req = sync_req;
    assign sync_int        = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic wr_hit;

        assign wr_hit = div_wr && (div_sel == SEL_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .wr      (wr_hit),
            .wr_data (div_data),
            .sync    (sync_int),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .rise    (rise[i]),
            .pend    (pend[i])
        );
    end

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//   Directed bench for clk_div_bank with NCH=2 and the default divisors 255/2047.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

    logic        clk;
    logic        rst_n;
    logic [1:0]  en;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [11:0] div_data;
    logic        sync_req;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  rise;
    logic [1:0]  pend;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    clk_div_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .sync_req (sync_req),
        .clk_out  (clk_out),
        .tick     (tick),
        .rise     (rise),
        .pend     (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock edge. The bench samples and drives 1 time unit after it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wr_div(input logic [1:0] sel, input logic [11:0] data);
        div_wr   = 1'b1;
        div_sel  = sel;
        div_data = data;
        step(1);
        div_wr   = 1'b0;
    endtask

    // Returns the cycle of the next tick (a rising tick if want_rise is set),
    // or -1 if no such tick arrives within max_cyc edges.
    task automatic wait_tick(input int ch, input bit want_rise, input int max_cyc,
                             output int at);
        bit found = 1'b0;
        at = -1;
        for (int k = 0; k < max_cyc && !found; k++) begin
            step(1);
            if (tick[ch] && (!want_rise || rise[ch])) begin
                found = 1'b1;
                at    = cyc;
            end
        end
    endtask

    initial begin
        int c0, t, r, e, s, r0, r1, e0, e1, f0, f1;
        int lvl1;

        rst_n = 1'b0; en = 2'b00; div_wr = 1'b0; div_sel = 2'd0;
        div_data = 12'd0; sync_req = 1'b0;

        // Reset state.
        step(2);
        check("rst_clk_out", clk_out, 0);
        check("rst_tick",    tick,    0);
        check("rst_rise",    rise,    0);
        check("rst_pend",    pend,    0);

        // Defaults: ch0 half-period 256, ch1 half-period 2048.
        rst_n = 1'b1; en = 2'b11; c0 = cyc;
        wait_tick(0, 1'b0, 300, t);
        check("ch0_first_tick", t, c0 + 256);
        check("ch0_first_high", clk_out[0], 1);
        check("ch0_first_rise", rise[0], 1);
        step(1);
        check("ch0_tick_width", tick[0], 0);
        check("ch0_rise_width", rise[0], 0);
        wait_tick(0, 1'b0, 300, t);
        check("ch0_second_tick", t, c0 + 512);
        check("ch0_fall_level", clk_out[0], 0);
        check("ch0_fall_norise", rise[0], 0);
        wait_tick(1, 1'b0, 2100, t);
        check("ch1_first_tick", t, c0 + 2048);
        check("ch1_first_rise", rise[1], 1);

        // ch0 divisor 3 written mid half-period: the current 256 stays, then 4.
        t = cyc;
        step(100);
        wr_div(2'd0, 12'd3);
        check("ch0_pend_set", pend[0], 1);
        check("ch1_pend_clear", pend[1], 0);
        wait_tick(0, 1'b0, 300, r);
        check("ch0_old_half", r, t + 256);
        check("ch0_pend_clr", pend[0], 0);
        wait_tick(0, 1'b0, 20, e);
        check("ch0_new_half_a", e, t + 260);
        wait_tick(0, 1'b0, 20, e);
        check("ch0_new_half_b", e, t + 264);

        // ch1 divisor 0 while disabled: no pend, then toggle every cycle.
        en = 2'b01;
        step(1);
        check("ch1_dis_low", clk_out[1], 0);
        wr_div(2'd1, 12'd0);
        check("ch1_dis_nopend", pend, 0);
        en = 2'b11;
        step(1);
        check("ch1_div0_hi", clk_out[1], 1);
        check("ch1_div0_rise", rise[1], 1);
        step(1);
        check("ch1_div0_lo", clk_out[1], 0);
        check("ch1_div0_tick", tick[1], 1);
        check("ch1_div0_norise", rise[1], 0);
        step(1);
        check("ch1_div0_hi2", clk_out[1], 1);

        // Disable ch0 during its high phase, then re-enable.
        wait_tick(0, 1'b1, 20, r);
        step(1);
        check("ch0_high_before_dis", clk_out[0], 1);
        en = 2'b10;
        step(1);
        check("ch0_dis_low", clk_out[0], 0);
        check("ch0_dis_notick", tick[0], 0);
        step(3);
        check("ch0_dis_stays_low", clk_out[0], 0);
        en = 2'b11; e = cyc;
        wait_tick(0, 1'b1, 20, r);
        check("ch0_reen_rise", r, e + 4);

        // Out-of-range select is ignored. Back-to-back writes: the last wins.
        step(1);
        wr_div(2'd3, 12'd1);
        check("sel3_nopend", pend, 0);
        wait_tick(0, 1'b0, 20, t);
        check("sel3_ignored", t, r + 4);
        step(1);
        wr_div(2'd0, 12'd5);
        wr_div(2'd0, 12'd9);
        check("b2b_pend", pend[0], 1);
        wait_tick(0, 1'b0, 20, t);
        check("b2b_old_half", t, r + 8);
        check("b2b_pend_clr", pend[0], 0);
        wait_tick(0, 1'b0, 20, t);
        check("b2b_half9_a", t, r + 18);
        wait_tick(0, 1'b0, 20, t);
        check("b2b_half9_b", t, r + 28);

        // Divisors 3 and 7, then a sync_req pulse.
        wr_div(2'd0, 12'd3);
        wr_div(2'd1, 12'd7);
        step(40);
        wait_tick(1, 1'b1, 40, r1);
        wait_tick(0, 1'b1, 20, r0);
        step(1);
        sync_req = 1'b1;
        step(1);
        sync_req = 1'b0;
        s = cyc;
        check("sync_pend", pend, 0);
`ifdef CLKDIV_SYNC_EN
        check("sync_clk_out", clk_out, 0);
        check("sync_tick", tick, 0);
        e0 = s + 4;
        e1 = s + 8;
`else
        lvl1 = (((s - r1) / 8) % 2 == 0) ? 1 : 0;
        check("nosync_ch0_level", clk_out[0], 1);
        check("nosync_ch1_level", clk_out[1], lvl1);
        e0 = r0 + 4;
        e1 = r1 + 8 * ((s - r1) / 8 + 1);
`endif
        f0 = -1; f1 = -1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (tick[0] && f0 < 0) f0 = cyc;
            if (tick[1] && f1 < 0) f1 = cyc;
        end
        check("after_sync_ch0_tick", f0, e0);
        check("after_sync_ch1_tick", f1, e1);

        // Reset while a write is pending discards it and restores the defaults.
        wr_div(2'd0, 12'd5);
        check("pre_rst_pend", pend[0], 1);
        rst_n = 1'b0;
        step(1);
        check("midrst_pend", pend, 0);
        check("midrst_clk_out", clk_out, 0);
        rst_n = 1'b1; c0 = cyc;
        wait_tick(0, 1'b0, 300, t);
        check("postrst_default", t, c0 + 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_clk_div_bank
